// File: rtl/perip_arb.sv
// Two-master arbiter in front of a single register-file style peripheral.
// Optional macro PERIP_ARB_RR_EN selects round-robin contention; default is fixed priority (master 0).
`timescale 1ns/1ps
`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 32
`endif
`ifndef INST_DATA_BUS
`define INST_DATA_BUS 32
`endif

module perip_arb (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                m_req_i,
  input  logic [1:0]                m_we_i,
  input  logic [`INST_ADDR_BUS-1:0] m0_addr_i,
  input  logic [`INST_ADDR_BUS-1:0] m1_addr_i,
  input  logic [`INST_DATA_BUS-1:0] m0_wdata_i,
  input  logic [`INST_DATA_BUS-1:0] m1_wdata_i,
  output logic [1:0]                m_gnt_o,
  output logic [1:0]                m_rvalid_o,
  output logic [`INST_DATA_BUS-1:0] m_rdata_o,
  output logic                      wr_en_o,
  output logic [`INST_ADDR_BUS-1:0] wr_addr_o,
  output logic [`INST_DATA_BUS-1:0] wr_data_o,
  output logic [`INST_ADDR_BUS-1:0] rd_addr_o,
  input  logic [`INST_DATA_BUS-1:0] rd_data_i
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate on any request
  // ACCESS | grant pulse, peripheral sees the owner's access
  // RESP   | registered read data returned to owner; arbitrate next
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      we_q, we_d;
  logic [`INST_ADDR_BUS-1:0] addr_q, addr_d;
  logic [`INST_DATA_BUS-1:0] wdata_q, wdata_d;
  logic                      arb_en;
  logic                      winner;

`ifdef PERIP_ARB_RR_EN
  logic last_q, last_d;
`endif

  always_comb begin
    arb_en = ((state_q == ST_IDLE) || (state_q == ST_RESP)) && (m_req_i != 2'b00);
    if (m_req_i == 2'b11) begin
`ifdef PERIP_ARB_RR_EN
      winner = ~last_q;
`else
      winner = 1'b0;
`endif
    end else begin
      // single requester (or none) always wins
      winner = m_req_i[1];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PERIP_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE:   if (m_req_i != 2'b00) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = (m_req_i != 2'b00) ? ST_ACCESS : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (arb_en) begin
      owner_d = winner;
      we_d    = m_we_i[winner];
      addr_d  = winner ? m1_addr_i : m0_addr_i;
      wdata_d = winner ? m1_wdata_i : m0_wdata_i;
`ifdef PERIP_ARB_RR_EN
      last_d  = winner;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef PERIP_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef PERIP_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // all outputs decode from registered state, so reset clears them at once
  always_comb begin
    m_gnt_o    = 2'b00;
    m_rvalid_o = 2'b00;
    m_rdata_o  = '0;
    wr_en_o    = 1'b0;
    wr_addr_o  = '0;
    wr_data_o  = '0;
    rd_addr_o  = '0;
    if (state_q == ST_ACCESS) begin
      m_gnt_o   = owner_q ? 2'b10 : 2'b01;
      wr_en_o   = we_q;
      wr_addr_o = addr_q;
      wr_data_o = wdata_q;
      rd_addr_o = addr_q;
    end
    if (state_q == ST_RESP) begin
      m_rvalid_o = owner_q ? 2'b10 : 2'b01;
      m_rdata_o  = rd_data_i;
    end
  end

endmodule

// File: doc/perip_arb.md
PERIP_ARB -- requirements
Module: perip_arb

Interface
REQ-001 SHALL have no parameters; address and data widths SHALL be `INST_ADDR_BUS / `INST_DATA_BUS (32 bits each) from the core defines.
REQ-002 SHALL use one clock and an active-low asynchronous reset:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
REQ-003 SHALL provide these master-side ports (index 0 = core, index 1 = debug/loader):
- m_req_i  in  2  per-master request; held with payload stable until gnt
- m_we_i  in  2  per-master write flag (0 = read)
- m0_addr_i, m1_addr_i  in  32  register address
- m0_wdata_i, m1_wdata_i  in  32  write data
- m_gnt_o  out  2  one-hot one-cycle grant pulse
- m_rvalid_o  out  2  one-hot one-cycle response pulse
- m_rdata_o  out  32  shared response data, valid while any m_rvalid_o bit is high
REQ-004 SHALL provide these peripheral-side ports:
- wr_en_o  out  1  write enable
- wr_addr_o  out  32  write address
- wr_data_o  out  32  write data
- rd_addr_o  out  32  read address
- rd_data_i  in  32  read data, registered in the peripheral (valid one cycle after address)

Function
REQ-005 SHALL implement FSM states IDLE, ACCESS, RESP; transitions: IDLE->ACCESS if any m_req_i bit is set, else stay; ACCESS->RESP unconditionally; RESP->ACCESS if any m_req_i bit is set, else RESP->IDLE.
REQ-006 SHALL arbitrate only in IDLE and RESP; at the arbitrating edge the winner's we/addr/wdata and index SHALL be latched into an owner register.
REQ-007 In ACCESS, m_gnt_o[owner] SHALL be 1 and wr_en_o = latched we, wr_addr_o = rd_addr_o = latched addr, wr_data_o = latched wdata.
REQ-008 Outside ACCESS, m_gnt_o, wr_en_o, wr_addr_o, wr_data_o and rd_addr_o SHALL all be 0.
REQ-009 In RESP, m_rvalid_o[owner] SHALL be 1 and m_rdata_o SHALL equal rd_data_i (combinational pass-through); otherwise m_rvalid_o = 0 and m_rdata_o = 0.
REQ-010 Writes SHALL also get an m_rvalid_o pulse; its m_rdata_o is the register value after the write.
REQ-011 Latency: req sampled high in IDLE at cycle N -> gnt plus peripheral access at N+1 -> rvalid at N+2. Back-to-back throughput SHALL be one transaction per 2 cycles.
REQ-012 A master SHALL deassert m_req_i on the edge after its gnt unless it starts a new transaction. A req still high in RESP SHALL be treated as a new request.
REQ-013 Single request: that master SHALL win regardless of priority state.
REQ-014 Simultaneous requests: winner SHALL be chosen per REQ-019/REQ-020; the loser's request SHALL stay pending and be served at the next arbitration point with no loss.
REQ-015 m_gnt_o and m_rvalid_o SHALL never have both bits set.

Reset
REQ-016 While rst_n = 0, the block SHALL go immediately to IDLE and all outputs SHALL be 0; the owner register SHALL be 0 and the last-owner pointer SHALL be 1.
REQ-017 Reset asserted during ACCESS or RESP SHALL abort the transaction with no rvalid; a write in flight during ACCESS may or may not have been committed by the peripheral.
REQ-018 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge at which m_req_i is nonzero.

Configuration
REQ-019 With macro PERIP_ARB_RR_EN defined: round-robin; on contention, the winner SHALL be the master other than the last-owner pointer, and the pointer SHALL update to the winner at each grant.
REQ-020 Without PERIP_ARB_RR_EN: fixed priority; master 0 SHALL always win contention, and the pointer SHALL be absent or unused.

Verification
REQ-021 Reset with m_req_i=2'b01 held -> all outputs 0 during reset; gnt 2'b01 on the 1st edge after release arbitrates.
REQ-022 m0 write addr 0x4 data 0x0000000A -> ACCESS cycle shows wr_en_o=1, wr_addr_o=0x4, wr_data_o=0xA, m_gnt_o=2'b01; next cycle m_rvalid_o=2'b01, m_rdata_o=0xA.
REQ-023 m1 read addr 0x4 after REQ-022 -> m_gnt_o=2'b10 with wr_en_o=0 and rd_addr_o=0x4; next cycle m_rvalid_o=2'b10, m_rdata_o=0xA.
REQ-024 Both masters request in the same IDLE cycle, three times in a row -> RR build: grants 01,10,01; fixed build: grants 01,01,01; m1 is served after each m0 response when m0 drops req.
REQ-025 Back-to-back m0 requests held continuously for 4 transactions -> states alternate ACCESS/RESP with no IDLE; 4 gnt and 4 rvalid pulses.
REQ-026 rst_n pulsed low during RESP -> m_rvalid_o drops to 0 immediately, FSM is IDLE, no further gnt without a new req.
